// File: rtl/alu_add_arbiter.sv
// alu_add_arbiter: shares one registered adder between two requesters.
// Round-robin grant in IDLE, operands registered toward the adder, the
// adder latency is waited out, then the tagged sum is returned on a single
// response channel that honours backpressure.
//
// state | meaning
// IDLE  | no op in flight; grant and operand handshake allowed
// WAIT  | operands held stable while the adder register latency elapses
// CAPT  | adder output valid; sum captured into rsp_data
// RESP  | response held on rsp_* until the consumer takes it
//
// ADD_LAT legal range is 1..7 (fits the 3-bit wait counter).
module alu_add_arbiter #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 13,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  output logic              req1_ready,
  output logic [DATA_W-1:0] add_x,
  output logic [DATA_W-1:0] add_y,
  input  logic [RES_W-1:0]  add_result,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_data,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_vld;
  logic             grant_id;

  // Round-robin grant, only offered while IDLE; a tie goes to the requester
  // that was not served last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld &  grant_id;
  assign busy       = (state != IDLE);

  // Sequencer: operand load, latency countdown, capture and response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      add_x      <= '0;
      add_y      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            add_x      <= grant_id ? req1_x : req0_x;
            add_y      <= grant_id ? req1_y : req0_y;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            wait_cnt   <= CNT_W'(ADD_LAT);
            state      <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            state <= CAPT;
          end
        end
        CAPT: begin
          // add_result is passed through untouched; upper bits are the
          // adder's responsibility.
          rsp_data  <= add_result;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
